// File: rtl/syn_av_mm_master.sv
// Avalon-MM master bridging a valid/ready command port to single read/write bus cycles,
// with one outstanding transaction, a per-state timeout and a stray readdatavalid counter.
module syn_av_mm_master #(
  parameter int unsigned ADDR_W  = 18,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic              clk_ir,
  input  logic              rst_il,
  input  logic              cmd_valid_ih,
  output logic              cmd_ready_oh,
  input  logic              cmd_write_ih,
  input  logic [ADDR_W-1:0] cmd_addr_id,
  input  logic [DATA_W-1:0] cmd_wdata_id,
  output logic              rsp_valid_oh,
  output logic              rsp_err_oh,
  output logic [DATA_W-1:0] rsp_data_od,
  output logic              av_read_oh,
  output logic              av_write_oh,
  output logic [ADDR_W-1:0] av_addr_od,
  output logic [DATA_W-1:0] av_write_data_od,
  input  logic              av_wait_req_ih,
  input  logic              av_read_data_valid_ih,
  input  logic [DATA_W-1:0] av_read_data_id,
  output logic [7:0]        stray_cnt_od
);

  typedef enum logic [2:0] {StIdle, StWr, StRdReq, StRdWait, StRsp} state_e;

  localparam logic [15:0] TmoLast = 16'(TIMEOUT - 1);

  state_e            state_q;
  logic [15:0]       tmo_cnt_q;
  logic              cmd_ready_q;
  logic              rsp_valid_q;
  logic              rsp_err_q;
  logic [DATA_W-1:0] rsp_data_q;
  logic              av_read_q;
  logic              av_write_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [7:0]        stray_cnt_q;

  logic tmo_hit;
  logic stray;

  assign tmo_hit = (tmo_cnt_q == TmoLast);
  // Readdatavalid only belongs to us while a read is on the bus or awaiting data.
  assign stray   = av_read_data_valid_ih &&
                   (state_q == StIdle || state_q == StWr || state_q == StRsp);

  always_ff @(posedge clk_ir) begin
    if (!rst_il) begin
      state_q     <= StIdle;
      tmo_cnt_q   <= '0;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= '0;
      av_read_q   <= 1'b0;
      av_write_q  <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      stray_cnt_q <= '0;
    end else begin
      if (stray && stray_cnt_q != 8'hff) begin
        stray_cnt_q <= stray_cnt_q + 8'd1;
      end
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= '0;

      unique case (state_q)
        StIdle: begin
          if (cmd_valid_ih && cmd_ready_q) begin
            cmd_ready_q <= 1'b0;
            addr_q      <= cmd_addr_id;
            wdata_q     <= cmd_wdata_id;
            tmo_cnt_q   <= '0;
            if (cmd_write_ih) begin
              state_q    <= StWr;
              av_write_q <= 1'b1;
            end else begin
              state_q   <= StRdReq;
              av_read_q <= 1'b1;
            end
          end else begin
            cmd_ready_q <= 1'b1;
          end
        end

        StWr: begin
          if (!av_wait_req_ih || tmo_hit) begin
            state_q     <= StRsp;
            av_write_q  <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= av_wait_req_ih;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 16'd1;
          end
        end

        StRdReq: begin
          if (!av_wait_req_ih) begin
            av_read_q <= 1'b0;
            if (av_read_data_valid_ih) begin
              state_q     <= StRsp;
              rsp_valid_q <= 1'b1;
              rsp_data_q  <= av_read_data_id;
            end else begin
              state_q   <= StRdWait;
              tmo_cnt_q <= '0;
            end
          end else if (tmo_hit) begin
            state_q     <= StRsp;
            av_read_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 16'd1;
          end
        end

        StRdWait: begin
          // Data arriving on the last allowed cycle beats the timeout.
          if (av_read_data_valid_ih) begin
            state_q     <= StRsp;
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= av_read_data_id;
          end else if (tmo_hit) begin
            state_q     <= StRsp;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 16'd1;
          end
        end

        StRsp: begin
          state_q     <= StIdle;
          cmd_ready_q <= 1'b1;
        end

        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign cmd_ready_oh     = cmd_ready_q;
  assign rsp_valid_oh     = rsp_valid_q;
  assign rsp_err_oh       = rsp_err_q;
  assign rsp_data_od      = rsp_data_q;
  assign av_read_oh       = av_read_q;
  assign av_write_oh      = av_write_q;
  assign av_addr_od       = addr_q;
  assign av_write_data_od = wdata_q;
  assign stray_cnt_od     = stray_cnt_q;

endmodule

// File: tb/tb_syn_av_mm_master.sv
// Bench for syn_av_mm_master: directed and random transactions against a reactive Avalon
// slave, with expected outcomes computed from wait-state/data-delay arithmetic.
module tb_syn_av_mm_master;

  localparam int unsigned AW  = 18;
  localparam int unsigned DW  = 32;
  localparam int unsigned TMO = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid;
  logic          rsp_err;
  logic [DW-1:0] rsp_data;
  logic          av_read;
  logic          av_write;
  logic [AW-1:0] av_addr;
  logic [DW-1:0] av_wdata;
  logic          av_wait_req;
  logic          av_rdv;
  logic [DW-1:0] av_rdata;
  logic [7:0]    stray_cnt;

  int checks      = 0;
  int failures    = 0;
  int stray_model = 0;

  always #5 clk = ~clk;

  syn_av_mm_master #(
    .ADDR_W (AW),
    .DATA_W (DW),
    .TIMEOUT(TMO)
  ) dut (
    .clk_ir               (clk),
    .rst_il               (rst_n),
    .cmd_valid_ih         (cmd_valid),
    .cmd_ready_oh         (cmd_ready),
    .cmd_write_ih         (cmd_write),
    .cmd_addr_id          (cmd_addr),
    .cmd_wdata_id         (cmd_wdata),
    .rsp_valid_oh         (rsp_valid),
    .rsp_err_oh           (rsp_err),
    .rsp_data_od          (rsp_data),
    .av_read_oh           (av_read),
    .av_write_oh          (av_write),
    .av_addr_od           (av_addr),
    .av_write_data_od     (av_wdata),
    .av_wait_req_ih       (av_wait_req),
    .av_read_data_valid_ih(av_rdv),
    .av_read_data_id      (av_rdata),
    .stray_cnt_od         (stray_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " cmd_ready"}, 64'(cmd_ready), 64'd0);
    chk({tag, " rsp_valid"}, 64'(rsp_valid), 64'd0);
    chk({tag, " rsp_err"},   64'(rsp_err),   64'd0);
    chk({tag, " rsp_data"},  64'(rsp_data),  64'd0);
    chk({tag, " av_read"},   64'(av_read),   64'd0);
    chk({tag, " av_write"},  64'(av_write),  64'd0);
    chk({tag, " av_addr"},   64'(av_addr),   64'd0);
    chk({tag, " av_wdata"},  64'(av_wdata),  64'd0);
    chk({tag, " stray"},     64'(stray_cnt), 64'd0);
  endtask

  // w: wait-request cycles before the slave accepts; d: cycles from accept to readdatavalid.
  task automatic run_txn(input string name, input bit wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] wd, input int w, input int d,
                         input logic [DW-1:0] rd, input bit noise);
    int exp_strobe, exp_lat, rdv_at, cyc, strobe_cnt, rsp_cnt, lat, bound;
    bit exp_err, exp_stray, bad_hold, wrong_strobe, ready_bad, got_rsp, ready_after, r_err;
    logic [DW-1:0] exp_data, r_data;

    // Outcome in cycles counted from the acceptance edge.
    exp_stray = 1'b0;
    if (w >= int'(TMO)) begin
      exp_err = 1'b1; exp_strobe = TMO; exp_lat = TMO + 1; exp_data = '0;
    end else if (wr) begin
      exp_err = 1'b0; exp_strobe = w + 1; exp_lat = w + 2; exp_data = '0;
    end else if (d <= int'(TMO)) begin
      exp_err = 1'b0; exp_strobe = w + 1; exp_lat = w + 2 + d; exp_data = rd;
    end else begin
      exp_err = 1'b1; exp_strobe = w + 1; exp_lat = w + 2 + int'(TMO); exp_data = '0;
      exp_stray = 1'b1;
    end

    bound = 0;
    while (!cmd_ready && bound < 50) begin
      @(negedge clk);
      bound++;
    end
    chk({name, " ready_before"}, 64'(cmd_ready), 64'd1);

    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = wd;
    @(negedge clk);
    cyc = 1; strobe_cnt = 0; rsp_cnt = 0; lat = 0; rdv_at = -1;
    got_rsp = 0; bad_hold = 0; wrong_strobe = 0; ready_bad = 0; ready_after = 0;
    r_err = 0; r_data = '0;
    while ((cyc <= exp_lat + 1 || cyc <= rdv_at) && cyc < 80) begin
      if (rsp_valid) begin
        rsp_cnt++;
        if (!got_rsp) begin
          got_rsp = 1; lat = cyc; r_err = rsp_err; r_data = rsp_data;
        end
      end
      if (cyc <= exp_lat && cmd_ready) ready_bad = 1;
      if (cyc == exp_lat + 1) ready_after = cmd_ready;
      if (wr ? av_read : av_write) wrong_strobe = 1;
      if (wr ? av_write : av_read) begin
        if (av_addr !== a || av_wdata !== wd) bad_hold = 1;
        av_wait_req = (strobe_cnt < w);
        if (!wr && strobe_cnt == w) rdv_at = cyc + d;
        strobe_cnt++;
      end else begin
        av_wait_req = 1'b1;
      end
      av_rdv   = (cyc == rdv_at);
      av_rdata = av_rdv ? rd : DW'($urandom);
      if (noise && cyc <= exp_lat) begin
        cmd_valid = 1'($urandom_range(0, 1));
        cmd_write = 1'($urandom);
        cmd_addr  = AW'($urandom);
        cmd_wdata = DW'($urandom);
      end else begin
        cmd_valid = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    av_rdv = 1'b0; av_wait_req = 1'b1; cmd_valid = 1'b0;
    if (exp_stray && stray_model < 255) stray_model++;

    chk({name, " rsp_latency"}, 64'(lat),          64'(exp_lat));
    chk({name, " rsp_err"},     64'(r_err),        64'(exp_err));
    chk({name, " rsp_data"},    64'(r_data),       64'(exp_data));
    chk({name, " rsp_pulses"},  64'(rsp_cnt),      64'd1);
    chk({name, " strobe_len"},  64'(strobe_cnt),   64'(exp_strobe));
    chk({name, " addr_hold"},   64'(bad_hold),     64'd0);
    chk({name, " wrong_strb"},  64'(wrong_strobe), 64'd0);
    chk({name, " ready_busy"},  64'(ready_bad),    64'd0);
    chk({name, " ready_after"}, 64'(ready_after),  64'd1);
    chk({name, " stray"},       64'(stray_cnt),    64'(stray_model));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    av_wait_req = 1'b1; av_rdv = 1'b0; av_rdata = '0;

    // Reset and release
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk("release cmd_ready", 64'(cmd_ready), 64'd1);

    // Directed cases
    run_txn("wr_zero_ws", 1'b1, 18'h00010, 32'hDEADBEEF, 0, 0, 32'h0, 1'b0);
    run_txn("rd_ws",      1'b0, 18'h3FFFF, 32'h0BADF00D, 3, 2, 32'h12345678, 1'b0);
    run_txn("rd_tmo",     1'b0, 18'h00155, 32'h0, 20, 0, 32'hCAFE0001, 1'b0);
    av_rdv = 1'b1; av_rdata = 32'hAAAA5555;
    @(negedge clk);
    av_rdv = 1'b0;
    stray_model++;
    @(negedge clk);
    chk("late_rdv stray", 64'(stray_cnt), 64'(stray_model));
    chk("late_rdv idle",  64'(cmd_ready), 64'd1);
    run_txn("rd_edge",    1'b0, 18'h00002, 32'h0, 0, 8, 32'h87654321, 1'b0);
    run_txn("rd_late",    1'b0, 18'h00003, 32'h0, 0, 9, 32'h11112222, 1'b0);
    run_txn("rd_same",    1'b0, 18'h00004, 32'h0, 2, 0, 32'h33334444, 1'b0);
    run_txn("wr_tmo",     1'b1, 18'h00005, 32'h55556666, 8, 0, 32'h0, 1'b0);
    run_txn("wr_edge",    1'b1, 18'h00006, 32'h77778888, 7, 0, 32'h0, 1'b1);

    // Random traffic with spurious command activity while busy
    for (int i = 0; i < 24; i++) begin
      run_txn("rand", 1'($urandom), AW'($urandom), DW'($urandom),
              int'($urandom_range(0, 10)), int'($urandom_range(0, 10)), DW'($urandom), 1'b1);
    end

    // Stray counter saturation in IDLE
    for (int i = 0; i < 300; i++) begin
      av_rdv = 1'b1; av_rdata = DW'($urandom);
      @(negedge clk);
    end
    av_rdv = 1'b0;
    stray_model = (stray_model + 300 > 255) ? 255 : stray_model + 300;
    @(negedge clk);
    chk("sat stray",     64'(stray_cnt), 64'(stray_model));
    chk("sat cmd_ready", 64'(cmd_ready), 64'd1);
    chk("sat av_read",   64'(av_read),   64'd0);
    chk("sat av_write",  64'(av_write),  64'd0);
    chk("sat rsp_valid", 64'(rsp_valid), 64'd0);

    // Reset while waiting for read data
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 18'h2AAAA; cmd_wdata = 32'h9;
    @(negedge clk);
    cmd_valid = 1'b0; av_wait_req = 1'b0;
    @(negedge clk);
    av_wait_req = 1'b1;
    chk("midrd strobe_off", 64'(av_read),   64'd0);
    chk("midrd busy",       64'(cmd_ready), 64'd0);
    rst_n = 1'b0;
    @(negedge clk);
    chk_reset_vals("midrd_reset");
    rst_n = 1'b1;
    stray_model = 0;
    @(negedge clk);
    chk("midrd release ready", 64'(cmd_ready), 64'd1);
    chk("midrd no_rsp",        64'(rsp_valid), 64'd0);
    run_txn("post_reset", 1'b0, 18'h01234, 32'h0, 1, 1, 32'hFEEDFACE, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/syn_av_mm_master.md
SYN_AV_MM_MASTER -- requirements
Module: syn_av_mm_master

Interface
REQ-001 SHALL have parameter ADDR_W, default 18, which sets the Avalon address width.
REQ-002 SHALL have parameter DATA_W, default 32, which sets the Avalon data width.
REQ-003 SHALL have parameter TIMEOUT, default 1023, which sets the maximum number of cycles spent waiting in a transaction state (1..65535).
REQ-004 Port clk_ir, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 Port rst_il, input, 1 bit: reset, synchronous and active-low.
REQ-006 Port cmd_valid_ih, input, 1 bit: command request.
REQ-007 Port cmd_ready_oh, output, 1 bit: command accepted when cmd_valid_ih and cmd_ready_oh are both 1.
REQ-008 Port cmd_write_ih, input, 1 bit: 1 = write, 0 = read.
REQ-009 Port cmd_addr_id, input, ADDR_W bits: transaction address.
REQ-010 Port cmd_wdata_id, input, DATA_W bits: write data.
REQ-011 Port rsp_valid_oh, output, 1 bit: one-cycle completion pulse.
REQ-012 Port rsp_err_oh, output, 1 bit: the transaction timed out; valid with rsp_valid_oh.
REQ-013 Port rsp_data_od, output, DATA_W bits: read data; valid with rsp_valid_oh.
REQ-014 Port av_read_oh, output, 1 bit: Avalon-MM read.
REQ-015 Port av_write_oh, output, 1 bit: Avalon-MM write.
REQ-016 Port av_addr_od, output, ADDR_W bits: Avalon address.
REQ-017 Port av_write_data_od, output, DATA_W bits: Avalon write data.
REQ-018 Port av_wait_req_ih, input, 1 bit: slave waitrequest.
REQ-019 Port av_read_data_valid_ih, input, 1 bit: slave readdatavalid.
REQ-020 Port av_read_data_id, input, DATA_W bits: slave readdata.
REQ-021 Port stray_cnt_od, output, 8 bits: count of unexpected readdatavalid pulses.

Function
REQ-022 The FSM SHALL have states IDLE, WR, RD_REQ, RD_WAIT and RSP, and SHALL allow at most one outstanding transaction.
REQ-023 cmd_ready_oh SHALL be 1 only in IDLE, and SHALL be a registered function of state.
REQ-024 On acceptance in cycle T, the block SHALL latch address and write data, and enter WR (write) or RD_REQ (read) at T+1.
REQ-025 av_write_oh SHALL be 1 exactly while in WR, and av_read_oh SHALL be 1 exactly while in RD_REQ.
REQ-026 av_addr_od and av_write_data_od SHALL hold the latched values, stable, throughout WR and RD_REQ.
REQ-027 In WR, the block SHALL go to RSP the cycle after av_wait_req_ih is sampled 0, with rsp_err_oh=0 and rsp_data_od=0.
REQ-028 In RD_REQ with av_wait_req_ih=0, the block SHALL go to RD_WAIT; if av_read_data_valid_ih=1 in that same cycle, it SHALL capture the data and go to RSP directly.
REQ-029 In RD_WAIT, when av_read_data_valid_ih=1, the block SHALL capture av_read_data_id into rsp_data_od and go to RSP.
REQ-030 RSP SHALL last exactly one cycle, with rsp_valid_oh=1, and SHALL then return to IDLE.
REQ-031 The response interface SHALL have no backpressure.
REQ-032 Minimum write latency with zero wait states: accept at T, av_write at T+1, rsp_valid at T+2, cmd_ready at T+3.
REQ-033 A 16-bit timeout counter SHALL clear on entry to WR, RD_REQ or RD_WAIT, and increment each cycle spent in those states.
REQ-034 When the timeout counter equals TIMEOUT-1 with no completion that cycle, the block SHALL deassert av_read_oh/av_write_oh and go to RSP with rsp_err_oh=1 and rsp_data_od=0.
REQ-035 If completion and timeout occur in the same cycle, completion SHALL win and rsp_err_oh SHALL be 0.
REQ-036 av_read_data_valid_ih=1 in IDLE, WR or RSP SHALL be ignored for data and SHALL increment stray_cnt_od.
REQ-037 stray_cnt_od SHALL saturate at 255.
REQ-038 A late readdatavalid arriving after a read timeout SHALL be counted as stray.
REQ-039 cmd_valid_ih outside IDLE SHALL have no effect.

Reset
REQ-040 With rst_il=0 at a clock edge, the block SHALL enter IDLE.
REQ-041 During reset, cmd_ready_oh SHALL be 0; it SHALL become 1 on the first cycle after rst_il returns to 1.
REQ-042 Reset values SHALL be: rsp_valid_oh=0, rsp_err_oh=0, rsp_data_od=0, av_read_oh=0, av_write_oh=0, av_addr_od=0, av_write_data_od=0, stray_cnt_od=0, timeout counter=0.
REQ-043 Reset mid-transaction SHALL abort it without issuing a response.

Verification
REQ-044 Write with zero wait states: write addr=0x00010, data=0xDEADBEEF, wait_req=0 -> av_write high exactly 1 cycle with those values; rsp_valid at T+2 with err=0.
REQ-045 Read with wait states: read addr=0x3FFFF, wait_req=1 for 3 cycles, readdatavalid 2 cycles after wait_req drops with data 0x12345678 -> av_read high 4 cycles; rsp_data=0x12345678, err=0.
REQ-046 Timeout: TIMEOUT=8, read with wait_req held at 1 -> av_read drops after 8 cycles; rsp_valid with err=1, data=0; a later readdatavalid makes stray_cnt_od=1.
REQ-047 Completion at timeout: TIMEOUT=8, readdatavalid on the 8th RD_WAIT cycle -> err=0, data captured.
REQ-048 Stray saturation: 300 readdatavalid pulses while in IDLE -> stray_cnt_od=255; FSM remains in IDLE.
REQ-049 Reset mid-read: rst_il=0 during RD_WAIT -> all outputs at reset values next cycle, no rsp_valid; cmd_ready=1 the first cycle after release.
